// File: rtl/timer_pkg.sv
// Shared constants for the 8-bit timer counting engine.
// Holds the default counter width, the clock-select encodings
// and the TSR bit positions, plus a helper that maps a clock
// select onto the prescaler compare mask.
package timer_pkg;

    localparam int DEFAULT_WIDTH = 8;

    // Clock-select encodings (tick = pclk / N)
    localparam logic [1:0] CKS_DIV2  = 2'b00;
    localparam logic [1:0] CKS_DIV4  = 2'b01;
    localparam logic [1:0] CKS_DIV8  = 2'b10;
    localparam logic [1:0] CKS_DIV16 = 2'b11;

    // TSR bit positions
    localparam int TSR_OVF = 0;
    localparam int TSR_UDF = 1;

    // Low bits of the divider that must all be ones for a tick.
    function automatic logic [3:0] cks_mask(input logic [1:0] cks);
        logic [3:0] m;
        m = 4'b0001;
        case (cks)
            CKS_DIV2:  m = 4'b0001;
            CKS_DIV4:  m = 4'b0011;
            CKS_DIV8:  m = 4'b0111;
            CKS_DIV16: m = 4'b1111;
            default:   m = 4'b0001;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Prescaler for the timer: a 4-bit free-running divider that
// advances while enabled and produces a combinational tick when
// the bits selected by cks are all ones. Changing cks does not
// clear the divider, so the next tick simply follows the new mask.
module timer_prescaler
    import timer_pkg::*;
(
    input  logic       pclk,
    input  logic       presetn,
    input  logic       en,
    input  logic       clr,
    input  logic [1:0] cks,
    output logic       tick
);

    logic [3:0] div_cnt;
    logic [3:0] mask;

    // Compare mask for the selected division ratio
    always_comb begin
        mask = cks_mask(cks);
    end

    // Tick when enabled and all selected divider bits are set
    always_comb begin
        tick = en && ((div_cnt & mask) == mask);
    end

    // Divider: cleared by reset, disable or counter load; else increments
    always_ff @(posedge pclk) begin
        if (!presetn) begin
            div_cnt <= 4'd0;
        end else if (clr || !en) begin
            div_cnt <= 4'd0;
        end else begin
            div_cnt <= div_cnt + 4'd1;
        end
    end

endmodule

// File: rtl/timer_counter_core.sv
// Counting engine of the APB timer: live count TCNT, sticky
// {udf, ovf} status TSR and one-cycle event strobes.
// Optional feature macro: TIMER_CNT_IRQ_EN adds input tier and a
// registered irq = |(tsr & tier). Without it neither port exists.
// A load has priority over a tick and never raises a flag. On TSR,
// software can only clear (write 0); a hardware set in the same
// cycle as a software clear wins.
module timer_counter_core
    import timer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             pclk,
    input  logic             presetn,
    input  logic [WIDTH-1:0] tdr,
    input  logic             load_pulse,
    input  logic             tcr_en,
    input  logic             tcr_dir,
    input  logic [1:0]       tcr_cks,
    input  logic             tsr_wr,
    input  logic [1:0]       tsr_wdata,
`ifdef TIMER_CNT_IRQ_EN
    input  logic [1:0]       tier,
    output logic             irq,
`endif
    output logic [WIDTH-1:0] tcnt,
    output logic [1:0]       tsr,
    output logic             ovf_pulse,
    output logic             udf_pulse
);

    logic             tick;
    logic             ovf_set;
    logic             udf_set;
    logic [WIDTH-1:0] tcnt_next;
    logic [1:0]       tsr_next;

    timer_prescaler u_prescaler (
        .pclk    (pclk),
        .presetn (presetn),
        .en      (tcr_en),
        .clr     (load_pulse),
        .cks     (tcr_cks),
        .tick    (tick)
    );

    // Wrap detection: only a real tick (not masked by a load) can flag
    always_comb begin
        ovf_set = tick && !load_pulse && !tcr_dir && (tcnt == {WIDTH{1'b1}});
        udf_set = tick && !load_pulse &&  tcr_dir && (tcnt == {WIDTH{1'b0}});
    end

    // Next count: load first, then a tick in the selected direction
    always_comb begin
        tcnt_next = tcnt;
        if (load_pulse) begin
            tcnt_next = tdr;
        end else if (tick) begin
            if (tcr_dir) begin
                tcnt_next = tcnt - WIDTH'(1);
            end else begin
                tcnt_next = tcnt + WIDTH'(1);
            end
        end
    end

    // Next status: software write-0-to-clear, then hardware sets on top
    always_comb begin
        tsr_next = tsr;
        if (tsr_wr) begin
            tsr_next = tsr & tsr_wdata;
        end
        if (ovf_set) begin
            tsr_next[TSR_OVF] = 1'b1;
        end
        if (udf_set) begin
            tsr_next[TSR_UDF] = 1'b1;
        end
    end

    // Counter, status and event strobe registers
    always_ff @(posedge pclk) begin
        if (!presetn) begin
            tcnt      <= '0;
            tsr       <= 2'b00;
            ovf_pulse <= 1'b0;
            udf_pulse <= 1'b0;
        end else begin
            tcnt      <= tcnt_next;
            tsr       <= tsr_next;
            ovf_pulse <= ovf_set;
            udf_pulse <= udf_set;
        end
    end

`ifdef TIMER_CNT_IRQ_EN
    // Interrupt follows the registered status one cycle later
    always_ff @(posedge pclk) begin
        if (!presetn) begin
            irq <= 1'b0;
        end else begin
            irq <= |(tsr & tier);
        end
    end
`endif

endmodule
